// File: rtl/sfir_pkg.sv
// Shared definitions for the symmetric FIR core: default sizes, derived
// output width and latency, and the coefficient-reload state encoding.
package sfir_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int NBTAP_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } sfir_state_e;

  // Full-precision output: pre-add grows one bit, multiply doubles, and the
  // NBTAP-way cascade adds clog2(NBTAP) bits of headroom.
  function automatic int sfir_osize(input int dsize, input int nbtap);
    return 2 * dsize + 1 + $clog2(nbtap);
  endfunction

  // Pair capture, pre-add, multiply, then one cascade add per tap.
  function automatic int sfir_lat(input int nbtap);
    return nbtap + 3;
  endfunction

endpackage

// File: rtl/sfir_if.sv
// Sample, coefficient and result signals of the symmetric FIR core.
interface sfir_if
  import sfir_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int NBTAP = NBTAP_DEF
);
  localparam int OSIZE = sfir_osize(DSIZE, NBTAP);

  logic signed [DSIZE-1:0] din;
  logic                    din_valid;
  logic                    din_ready;
  logic                    coef_load;
  logic                    coef_wr;
  logic signed [DSIZE-1:0] coef_in;
  logic signed [OSIZE-1:0] dout;
  logic                    dout_valid;

  modport slave (
    input  din, din_valid, coef_load, coef_wr, coef_in,
    output din_ready, dout, dout_valid
  );

  modport master (
    output din, din_valid, coef_load, coef_wr, coef_in,
    input  din_ready, dout, dout_valid
  );
endinterface

// File: rtl/sfir_tap.sv
// One symmetric tap slice: pair capture, pre-add, multiply, a TAP_IDX-deep
// product delay that lines the product up with the cascade, and the
// cascade add. Valid bits travel alongside the data.
module sfir_tap
  import sfir_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int OSIZE   = sfir_osize(DSIZE_DEF, NBTAP_DEF),
  parameter int TAP_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_i,
  input  logic signed [DSIZE-1:0] a_i,
  input  logic signed [DSIZE-1:0] b_i,
  input  logic signed [DSIZE-1:0] coef_i,
  input  logic signed [OSIZE-1:0] sum_i,
  output logic signed [OSIZE-1:0] sum_o,
  output logic                    vld_o,
  output logic                    busy_o
);
  localparam int AW = DSIZE + 1;
  localparam int PW = 2 * DSIZE + 1;

  logic signed [DSIZE-1:0] a_p1, b_p1;
  logic signed [AW-1:0]    pre_p2;
  logic signed [PW-1:0]    prod_p3 [0:TAP_IDX];
  logic signed [OSIZE-1:0] sum_p4;
  logic                    vld_p1, vld_p2, vld_p4;
  logic [TAP_IDX:0]        vld_p3;

  function automatic logic signed [AW-1:0] pre_add(input logic signed [DSIZE-1:0] a,
                                                   input logic signed [DSIZE-1:0] b);
    return AW'(a) + AW'(b);
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [AW-1:0] p,
                                               input logic signed [DSIZE-1:0] c);
    return PW'(p) * PW'(c);
  endfunction

  function automatic logic signed [OSIZE-1:0] acc(input logic signed [OSIZE-1:0] s,
                                                  input logic signed [PW-1:0] p);
    return s + OSIZE'(p);
  endfunction

  // Free-running datapath; only entries tagged valid are meaningful.
  always_ff @(posedge clk) begin
    // p1: symmetric pair
    a_p1 <= a_i;
    b_p1 <= b_i;
    // p2: pre-add
    pre_p2 <= pre_add(a_p1, b_p1);
    // p3: multiply, then delay by tap position
    prod_p3[0] <= mul(pre_p2, coef_i);
    for (int i = 1; i <= TAP_IDX; i++) prod_p3[i] <= prod_p3[i-1];
    // p4: cascade add
    sum_p4 <= acc(sum_i, prod_p3[TAP_IDX]);
  end

  // Valid bits follow the data stage for stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= '0;
      vld_p4 <= 1'b0;
    end else begin
      vld_p1    <= vld_i;
      vld_p2    <= vld_p1;
      vld_p3[0] <= vld_p2;
      for (int i = 1; i <= TAP_IDX; i++) vld_p3[i] <= vld_p3[i-1];
      vld_p4    <= vld_p3[TAP_IDX];
    end
  end

  assign sum_o  = sum_p4;
  assign vld_o  = vld_p4;
  assign busy_o = vld_p1 | vld_p2 | (|vld_p3);

endmodule

// File: rtl/sfir_symmetric_core.sv
// Even-symmetric systolic FIR core with a valid-gated sample history and a
// coefficient reload sequence that drains in-flight samples before the
// live coefficient set is swapped in one cycle.
module sfir_symmetric_core
  import sfir_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int NBTAP = NBTAP_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  sfir_if.slave   bus
);
  localparam int OSIZE = sfir_osize(DSIZE, NBTAP);
  localparam int LAT   = sfir_lat(NBTAP);
  localparam int NT    = 2 * NBTAP;
  localparam int NH    = NT - 1;
  localparam int IW    = $clog2(NBTAP);
  localparam int CW    = $clog2(LAT);

  sfir_state_e             state_q, state_d;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           cnt_q;
  // Stored history plus the incoming sample form the 2*NBTAP-deep window,
  // so a sample's pairs are captured on the same edge it is accepted.
  logic signed [DSIZE-1:0] hist_q   [0:NH-1];
  logic signed [DSIZE-1:0] win      [0:NT-1];
  logic signed [DSIZE-1:0] coef_q   [0:NBTAP-1];
  logic signed [DSIZE-1:0] shadow_q [0:NBTAP-2];
  logic signed [OSIZE-1:0] casc     [0:NBTAP];
  logic [NBTAP-1:0]        tap_vld, tap_busy;
  logic signed [OSIZE-1:0] dout_q;
  logic                    dout_vld_q;
  logic                    accept, pipe_busy, drain_done, last_wr, out_en;

  assign bus.din_ready = (state_q == ST_RUN);
  assign accept        = bus.din_valid && bus.din_ready;
  assign pipe_busy     = (|tap_busy) || (|tap_vld);
  assign drain_done    = (cnt_q == CW'(LAT - 1)) && !pipe_busy;
  assign last_wr       = (state_q == ST_LOAD) && bus.coef_wr && (idx_q == IW'(NBTAP - 1));
  assign out_en        = tap_vld[NBTAP-1] && (state_q != ST_LOAD);

  // Sample window seen by the taps: newest sample first.
  always_comb begin
    win[0] = bus.din;
    for (int j = 1; j < NT; j++) win[j] = hist_q[j-1];
  end

  // History shifts only on accepted samples, so input gaps are invisible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NH; i++) hist_q[i] <= '0;
    end else if (accept) begin
      hist_q[0] <= bus.din;
      for (int i = 1; i < NH; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  // Reload sequencing: RUN -> DRAIN on request, DRAIN -> LOAD once empty,
  // LOAD -> RUN on the last coefficient write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (bus.coef_load) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)    state_d = ST_LOAD;
      ST_LOAD:  if (last_wr)       state_d = ST_RUN;
      default:                     state_d = ST_RUN;
    endcase
  end

  // State register, drain counter and coefficient index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != ST_DRAIN)          cnt_q <= '0;
      else if (cnt_q != CW'(LAT - 1))   cnt_q <= cnt_q + CW'(1);
      if (state_q == ST_LOAD && bus.coef_wr) idx_q <= last_wr ? '0 : idx_q + IW'(1);
    end
  end

  // Writes land in the shadow set; the final write publishes the whole set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBTAP; i++)     coef_q[i]   <= '0;
      for (int i = 0; i < NBTAP - 1; i++) shadow_q[i] <= '0;
    end else if (state_q == ST_LOAD && bus.coef_wr) begin
      if (last_wr) begin
        for (int i = 0; i < NBTAP - 1; i++) coef_q[i] <= shadow_q[i];
        coef_q[NBTAP-1] <= bus.coef_in;
      end else begin
        shadow_q[idx_q] <= bus.coef_in;
      end
    end
  end

  assign casc[0] = '0;

  for (genvar k = 0; k < NBTAP; k++) begin : g_tap
    sfir_tap #(
      .DSIZE   (DSIZE),
      .OSIZE   (OSIZE),
      .TAP_IDX (k)
    ) u_tap (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (accept),
      .a_i    (win[k]),
      .b_i    (win[NT-1-k]),
      .coef_i (coef_q[k]),
      .sum_i  (casc[k]),
      .sum_o  (casc[k+1]),
      .vld_o  (tap_vld[k]),
      .busy_o (tap_busy[k])
    );
  end

  // Output register: holds its value between results, silent during LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= out_en;
      if (out_en) dout_q <= casc[NBTAP];
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_vld_q;

endmodule

// File: tb/tb_sfir_symmetric_core.sv
// Scoreboard bench for sfir_symmetric_core: a reference model computes
// y[n] from the accepted-sample history and the loaded coefficients; a
// monitor checks value and arrival cycle of every dout_valid.
module tb_sfir_symmetric_core;
  import sfir_pkg::*;

  localparam int DSIZE = 16;
  localparam int NBTAP = 4;
  localparam int NT    = 2 * NBTAP;
  localparam int LAT   = sfir_lat(NBTAP);

  typedef struct {
    longint y;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfir_if #(.DSIZE(DSIZE), .NBTAP(NBTAP)) bus ();

  sfir_symmetric_core #(.DSIZE(DSIZE), .NBTAP(NBTAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     model_h [NBTAP];
  int     xh [NT];
  exp_t   sb [$];
  longint last_dout = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // y[n] = sum_k h[k] * (x[n-k] + x[n-(2N-1-k)])
  function automatic longint ref_y();
    longint s = 0;
    for (int k = 0; k < NBTAP; k++)
      s += longint'(model_h[k]) * (longint'(xh[k]) + longint'(xh[NT-1-k]));
    return s;
  endfunction

  // Reference model: observes accepts just before the sampling edge.
  initial begin : model
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        foreach (xh[j]) xh[j] = 0;
        sb.delete();
      end else if (bus.din_valid && bus.din_ready) begin
        for (int j = NT - 1; j > 0; j--) xh[j] = xh[j-1];
        xh[0] = int'(bus.din);
        e.y   = ref_y();
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_dout = 0;
      end else if (bus.dout_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: dout=%0d with nothing pending (cycle %0d)",
                   longint'(bus.dout), cyc);
        end else begin
          e = sb.pop_front();
          check("dout_value", longint'(bus.dout), e.y);
          check("dout_latency", longint'(cyc), longint'(e.due));
        end
        last_dout = longint'(bus.dout);
      end else begin
        check("dout_hold", longint'(bus.dout), last_dout);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_valid: got no output, expected %0d due at cycle %0d", e.y, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input bit v);
    bus.din       = DSIZE'(x);
    bus.din_valid = v;
    tick();
    bus.din_valid = 1'b0;
  endtask

  // Full reload: request, wait out the drain (with an ignored write), then
  // write h[0..N-1] with gaps (with an ignored reload request inside one gap).
  task automatic load(input int h[NBTAP], input bit with_sample, input int x, input int gap);
    bus.coef_load = 1'b1;
    bus.din       = DSIZE'(x);
    bus.din_valid = with_sample;
    tick();
    bus.coef_load = 1'b0;
    bus.din_valid = 1'b0;
    check("ready_low_drain", longint'(bus.din_ready), 0);
    for (int i = 0; i < LAT + 5; i++) begin
      bus.coef_wr = (i == 2);
      bus.coef_in = 16'sh7fff;
      tick();
    end
    bus.coef_wr = 1'b0;
    for (int k = 0; k < NBTAP; k++) begin
      check("ready_low_load", longint'(bus.din_ready), 0);
      check("no_valid_load", longint'(bus.dout_valid), 0);
      bus.coef_wr = 1'b1;
      bus.coef_in = DSIZE'(h[k]);
      if (k == NBTAP - 1) model_h = h;
      tick();
      bus.coef_wr = 1'b0;
      if (k == NBTAP - 1) begin
        check("ready_high_after_load", longint'(bus.din_ready), 1);
      end else begin
        for (int g = 0; g < gap; g++) begin
          bus.coef_load = (g == 0);
          tick();
        end
        bus.coef_load = 1'b0;
      end
    end
  endtask

  task automatic impulse(input bit gapped);
    send(1, 1'b1);
    if (gapped) send(0, 1'b0);
    for (int i = 0; i < NT - 1; i++) begin
      send(0, 1'b1);
      if (gapped) send(0, 1'b0);
    end
  endtask

  task automatic flush();
    repeat (LAT + 3) send(0, 1'b0);
  endtask

  initial begin : stim
    int h_a [NBTAP];
    int h_b [NBTAP];
    int h_m [NBTAP];
    int h_z [NBTAP];
    int h_r [NBTAP];
    bus.din = '0; bus.din_valid = 1'b0; bus.coef_load = 1'b0;
    bus.coef_wr = 1'b0; bus.coef_in = '0;
    foreach (model_h[k]) model_h[k] = 0;
    h_a = '{1, 2, 3, 4};
    h_b = '{4, 3, 2, 1};
    h_m = '{-32768, -32768, -32768, -32768};
    h_z = '{0, 0, 0, 0};

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_dout", longint'(bus.dout), 0);
    check("reset_dout_valid", longint'(bus.dout_valid), 0);
    check("reset_din_ready", longint'(bus.din_ready), 1);
    rst_n = 1'b1;
    tick();

    // Impulse, DC, and gapped impulse with h = {1,2,3,4}
    load(h_a, 1'b0, 0, 0);
    impulse(1'b0);
    flush();
    repeat (12) send(1, 1'b1);
    check("dc_steady", ref_y(), 20);
    flush();
    repeat (NT) send(0, 1'b1);
    impulse(1'b1);
    flush();

    // Extreme values
    load(h_m, 1'b0, 0, 1);
    repeat (12) send(-32768, 1'b1);
    repeat (LAT) tick();
    check("extreme_steady", longint'(bus.dout), 64'sd8589934592);
    flush();

    // Reload with a sample accepted alongside coef_load
    load(h_a, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) send($urandom_range(0, 200), 1'b1);
    load(h_b, 1'b1, 5, 2);
    repeat (NT) send(0, 1'b1);
    impulse(1'b0);
    flush();

    // Reset in the middle of LOAD discards the partial set
    bus.coef_load = 1'b1;
    tick();
    bus.coef_load = 1'b0;
    repeat (LAT + 5) tick();
    for (int k = 0; k < 2; k++) begin
      bus.coef_wr = 1'b1;
      bus.coef_in = 16'sd9;
      tick();
    end
    bus.coef_wr = 1'b0;
    rst_n   = 1'b0;
    model_h = h_z;
    tick();
    check("midload_reset_dout", longint'(bus.dout), 0);
    check("midload_reset_dout_valid", longint'(bus.dout_valid), 0);
    check("midload_reset_din_ready", longint'(bus.din_ready), 1);
    rst_n = 1'b1;
    impulse(1'b0);
    flush();

    // Randomized traffic with stray coef_wr in RUN, two random reloads
    for (int pass = 0; pass < 2; pass++) begin
      foreach (h_r[k]) h_r[k] = int'($urandom_range(0, 65535)) - 32768;
      load(h_r, 1'b1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)));
      for (int i = 0; i < 150; i++) begin
        bus.coef_wr = ($urandom_range(0, 9) == 0);
        bus.coef_in = DSIZE'($urandom);
        send(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 2) != 0));
      end
      bus.coef_wr = 1'b0;
    end
    flush();

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sfir_symmetric_core.md
Name: sfir_symmetric_core

Overview:
Even-symmetric systolic FIR datapath, 2*NBTAP taps, NBTAP stored coefficients. Computes y[n] = sum_{k=0..NBTAP-1} h[k]*(x[n-k] + x[n-(2*NBTAP-1-k)]) at full precision.
Sits downstream of the sample delay line. Adds a valid-gated sample history, a pre-add/multiply/cascade pipeline and a coefficient-reload state machine that drains in-flight samples before coefficients change.

Parameters:
DSIZE, 16, sample and coefficient width (signed two's complement).
NBTAP, 4, stored coefficients; filter length is 2*NBTAP; minimum 2.
OSIZE, 2*DSIZE+1+clog2(NBTAP) (35 at defaults), output width; full precision, no rounding or saturation.
LAT, NBTAP+3, fixed cycles from accepted sample to its output.

Ports:
clk  in  1  rising-edge clock, single domain.
rst_n  in  1  synchronous, active-low reset.
din  in  DSIZE  signed input sample.
din_valid  in  1  sample offered this cycle.
din_ready  out  1  block accepts a sample; a sample is accepted when din_valid && din_ready.
coef_load  in  1  one-cycle request to reload coefficients.
coef_wr  in  1  coefficient write strobe, honoured only in LOAD.
coef_in  in  DSIZE  signed coefficient; written in order h[0], h[1], ..., h[NBTAP-1].
dout  out  OSIZE  signed filter output.
dout_valid  out  1  dout holds y for the sample accepted LAT cycles earlier.

Behaviour:
- Reset (rst_n=0 at a clk edge): history and all coefficients cleared to 0; pipeline valid bits cleared; state RUN.
  Output reset values: dout=0, dout_valid=0, din_ready=1 from the first cycle after reset.
  Reset mid-DRAIN or mid-LOAD aborts the operation; a partially written coefficient set is discarded (all zeros).
- History: a 2*NBTAP-deep sample register advances only on accepted samples. Gaps in din_valid do not change results.
- Pipeline: free-running, with a valid bit per stage.
  Stage 1: register the symmetric pair.
  Stage 2: pre-add, DSIZE+1 bits.
  Stage 3: multiply, 2*DSIZE+1 bits.
  Then NBTAP systolic add stages.
  dout and dout_valid are registered. dout_valid pulses exactly LAT cycles after each accept. dout holds its last value when dout_valid=0.
- All arithmetic is sign-extended; the sum never overflows at OSIZE.
- FSM states:
  RUN: din_ready=1. coef_load=1 -> DRAIN. A sample accepted in the same cycle as coef_load is processed with the old coefficients.
  DRAIN: din_ready=0. Drain counter counts LAT cycles, until no pipeline valid bit is set, then -> LOAD. Outputs continue to emerge with the old coefficients.
  LOAD: din_ready=0, dout_valid=0. Index counter 0..NBTAP-1. Each coef_wr writes coef_in to h[idx] and increments idx. The write at idx=NBTAP-1 moves to RUN and clears idx.
- In LOAD, coefficients are written into a shadow set. The live set is updated in a single cycle on the LOAD->RUN transition.
- Sample history is retained across reloads.
- Ignored inputs (no effect): coef_load in DRAIN or LOAD; coef_wr in RUN or DRAIN.
- No timeout in LOAD. The block waits indefinitely for coef_wr.

Decomposition:
- Shared package sfir_pkg: default DSIZE/NBTAP, the OSIZE and LAT derivation functions, and the FSM state enum (RUN, DRAIN, LOAD).
- One natural sub-module: sfir_tap. It holds one pre-add, multiply and cascade-add slice with its own valid bit; it is instantiated NBTAP times in the generate loop.
- FSM, counters and history stay in the top module.

Test Plan:
- Impulse response: load h={1,2,3,4}, then send 1 followed by 7 zeros, din_valid held high.
  Required: dout = 1,2,3,4,4,3,2,1 on consecutive dout_valid cycles; the first dout_valid occurs 7 cycles after the impulse is accepted.
- DC input: h={1,2,3,4}, constant x=1. After 8 samples accepted, every dout = 20.
- Extreme values: all h=-32768, all x=-32768. Steady-state dout = 2^33 (positive) with no wrap.
- Gapped valid: repeat the impulse test with din_valid high only on alternate cycles.
  Required: same output values, each dout_valid exactly 7 cycles after its sample.
- Reload: send samples with h={1,2,3,4}, pulse coef_load together with a valid sample, then write {4,3,2,1} with gaps between coef_wr.
  Required: din_ready low from the next cycle; 7 cycles of old-coefficient outputs (including the sample accepted with coef_load); no dout_valid in LOAD; din_ready high after the 4th write; the impulse response then reads 4,3,2,1,1,2,3,4.
- Reset mid-LOAD: assert rst_n=0 after 2 coef_wr.
  Required: next cycle dout=0, dout_valid=0, din_ready=1, state RUN; an impulse afterwards gives all-zero outputs.
